// File: rtl/mem_ctrl_pkg.sv
// Shared constants and encodings for the byte-serial memory controller.
// Line geometry, the IO-region tag, FSM states and the requester select live here.
package mem_ctrl_pkg;

  localparam int ADDR_WID        = 32;
  localparam int LINE_BYTES      = 64;
  localparam int ICACHE_LINE_WID = 8 * LINE_BYTES;
  localparam int CNT_WID         = 7;

  localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    SEL_IF  = 1'b0,
    SEL_LSB = 1'b1
  } sel_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of RAM, IFetch and LSB signals around the memory controller.
// Requests are level-held until the matching one-cycle done pulse is seen.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                       rdy;
  logic                       rollback;
  logic [7:0]                 mem_din;
  logic [7:0]                 mem_dout;
  logic [ADDR_WID-1:0]        mem_a;
  logic                       mem_wr;
  logic                       io_buffer_full;

  logic                       if_en;
  logic [ADDR_WID-1:0]        if_pc;
  logic                       if_done;
  logic [ICACHE_LINE_WID-1:0] if_data;

  logic                       lsb_en;
  logic                       lsb_wr;
  logic [ADDR_WID-1:0]        lsb_addr;
  logic [2:0]                 lsb_len;
  logic [31:0]                lsb_wdata;
  logic                       lsb_done;
  logic [31:0]                lsb_rdata;

  state_e                     dbg_state;

  modport slave (
    input  rdy, rollback, mem_din, io_buffer_full,
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata,
    output dbg_state
  );

  modport master (
    output rdy, rollback, mem_din, io_buffer_full,
    output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata,
    input  dbg_state
  );

endinterface

// File: rtl/mem_ctrl.sv
// Serialises I-cache line fills and LSB loads/stores into byte RAM accesses.
// Single FSM, LSB has priority over IFetch; read bytes shift into a line buffer.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  localparam int                  LW        = ICACHE_LINE_WID;
  localparam logic [CNT_WID-1:0]  LINE_CNT  = CNT_WID'(LINE_BYTES);
  localparam logic [ADDR_WID-1:0] LINE_MASK = ADDR_WID'(LINE_BYTES - 1);

  state_e               state_q, state_d;
  sel_e                 sel_q, sel_d;
  logic [CNT_WID-1:0]   cnt_q, cnt_d;
  logic [CNT_WID-1:0]   len_q, len_d;
  logic [ADDR_WID-1:0]  base_q, base_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 io_q, io_d;
  logic [LW-1:0]        buf_q, buf_d;
  logic [LW-1:0]        if_data_q, if_data_d;
  logic [31:0]          lsb_rdata_q, lsb_rdata_d;
  logic                 if_done_q, if_done_d;
  logic                 lsb_done_q, lsb_done_d;

  logic                 io_stall;
  logic                 issuing_rd;
  logic                 issuing_wr;
  logic [LW-1:0]        shifted;
  logic [31:0]          top_word;

  // RAM-side outputs are decoded from registered state so they are glitch-free
  // and forced to zero whenever no byte is being issued.
  assign io_stall   = io_q && bus.io_buffer_full;
  assign issuing_rd = (state_q == READ) && (cnt_q < len_q);
  assign issuing_wr = (state_q == WRITE) && !io_stall;

  assign bus.mem_a    = (issuing_rd || issuing_wr)
                        ? base_q + {{(ADDR_WID-CNT_WID){1'b0}}, cnt_q}
                        : '0;
  assign bus.mem_wr   = issuing_wr;
  assign bus.mem_dout = issuing_wr ? 8'(wdata_q >> {cnt_q[1:0], 3'b000}) : 8'h00;

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign bus.dbg_state = state_q;

  // Bytes enter at the top, so after N captures the N newest bytes sit in the
  // top 8N bits in address order; a right shift zero-extends a short load.
  assign shifted  = {bus.mem_din, buf_q[LW-1:8]};
  assign top_word = shifted[LW-1 -: 32];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    io_d        = io_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A held request must not be re-accepted while its done is visible.
        if (!if_done_q && !lsb_done_q) begin
          if (bus.lsb_en && !bus.rollback) begin
            sel_d   = SEL_LSB;
            base_d  = bus.lsb_addr;
            len_d   = (bus.lsb_len == 3'd0) ? CNT_WID'(1) : CNT_WID'(bus.lsb_len);
            wdata_d = bus.lsb_wdata;
            io_d    = bus.lsb_wr && (bus.lsb_addr[17:16] == IO_ADDR_HI);
            cnt_d   = '0;
            state_d = bus.lsb_wr ? WRITE : READ;
          end else if (bus.if_en) begin
            sel_d   = SEL_IF;
            base_d  = bus.if_pc & ~LINE_MASK;
            len_d   = LINE_CNT;
            io_d    = 1'b0;
            cnt_d   = '0;
            state_d = READ;
          end
        end
      end

      READ: begin
        if (sel_q == SEL_LSB && bus.rollback) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Data for the address issued at count k arrives two edges later.
          if (cnt_q != '0) buf_d = shifted;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (sel_q == SEL_IF) begin
              if_data_d = shifted;
              if_done_d = 1'b1;
            end else begin
              unique case (len_q)
                CNT_WID'(1): lsb_rdata_d = top_word >> 24;
                CNT_WID'(2): lsb_rdata_d = top_word >> 16;
                default:     lsb_rdata_d = top_word;
              endcase
              lsb_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WID'(1);
          end
        end
      end

      WRITE: begin
        if (!io_stall) begin
          if (cnt_q == len_q - CNT_WID'(1)) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WID'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= SEL_IF;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      io_q        <= 1'b0;
      buf_q       <= '0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
    end else if (bus.rdy) begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      io_q        <= io_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: registered-output byte RAM model, write scoreboard,
// and a linear sequence of line fills, loads, stores, rollbacks, IO stall and reset.
`define CHK(tag, got, exp) \
  begin \
    n_checks++; \
    assert ((got) === (exp)) else begin \
      n_errors++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp); \
    end \
  end

module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte RAM with one cycle of registered read latency.
  logic [7:0]  ram [0:262143];
  logic [31:0] a_s;
  logic [39:0] exp_q [$];

  always @(negedge clk) a_s = bus.mem_a;

  always @(posedge clk) begin
    if (bus.rdy) bus.mem_din <= ram[a_s[17:0]];
  end

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      logic [39:0] exp_w;
      ram[bus.mem_a[17:0]] = bus.mem_dout;
      `CHK("wr_expected", (exp_q.size() != 0), 1'b1)
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        `CHK("wr_addr_data", {bus.mem_a, bus.mem_dout}, exp_w)
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_if, input int limit, output int e);
    e = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if ((is_if ? bus.if_done : bus.lsb_done) === 1'b1) begin
        e = k;
        return;
      end
    end
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] addr,
                         input logic [2:0] len, input logic [31:0] wdata);
    bus.lsb_wr    = wr;
    bus.lsb_addr  = addr;
    bus.lsb_len   = len;
    bus.lsb_wdata = wdata;
    bus.lsb_en    = 1'b1;
  endtask

  initial begin
    int e;
    int bad;
    int done_e;

    for (int i = 0; i < 262144; i++) ram[i] = i[7:0];
    ram[18'h200] = 8'h11;
    ram[18'h201] = 8'h22;
    ram[18'h202] = 8'h33;
    ram[18'h203] = 8'h44;

    bus.rdy            = 1'b1;
    bus.rollback       = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_en          = 1'b0;
    bus.if_pc          = '0;
    bus.lsb_en         = 1'b0;
    bus.lsb_wr         = 1'b0;
    bus.lsb_addr       = '0;
    bus.lsb_len        = 3'd0;
    bus.lsb_wdata      = '0;

    // Reset state
    tick();
    tick();
    `CHK("rst_state", bus.dbg_state, IDLE)
    `CHK("rst_mem_a", bus.mem_a, 32'h0)
    `CHK("rst_mem_wr", bus.mem_wr, 1'b0)
    `CHK("rst_mem_dout", bus.mem_dout, 8'h00)
    `CHK("rst_if_done", bus.if_done, 1'b0)
    `CHK("rst_lsb_done", bus.lsb_done, 1'b0)
    `CHK("rst_lsb_rdata", bus.lsb_rdata, 32'h0)
    `CHK("rst_if_data", bus.if_data[63:0], 64'h0)
    rst = 1'b0;
    tick();

    // 1. Line fill from unaligned pc; en held one extra edge after done
    bus.if_pc = 32'h0000_1047;
    bus.if_en = 1'b1;
    tick();
    `CHK("fill_first_addr", bus.mem_a, 32'h0000_1040)
    bad = 0;
    done_e = 0;
    for (int k = 1; k <= 70 && done_e == 0; k++) begin
      tick();
      if (k <= 63 && bus.mem_a !== 32'h0000_1040 + 32'(k)) bad++;
      if (k == 64 && bus.mem_a !== 32'h0) bad++;
      if (bus.if_done === 1'b1) done_e = k;
    end
    `CHK("fill_addr_walk", bad, 0)
    `CHK("fill_done_edge", done_e, 65)
    `CHK("fill_data_lo", bus.if_data[31:0], 32'h4342_4140)
    `CHK("fill_data_hi", bus.if_data[511:504], 8'h7F)
    tick();
    bus.if_en = 1'b0;
    `CHK("fill_done_pulse", bus.if_done, 1'b0)
    `CHK("fill_no_reaccept", bus.dbg_state, IDLE)
    `CHK("fill_idle_addr", bus.mem_a, 32'h0)

    // 2. Word load, en held one extra edge; then byte load
    lsb_req(1'b0, 32'h200, 3'd4, 32'h0);
    tick();
    `CHK("ld4_first_addr", bus.mem_a, 32'h200)
    wait_done(1'b0, 10, e);
    `CHK("ld4_done_edge", e, 5)
    `CHK("ld4_rdata", bus.lsb_rdata, 32'h4433_2211)
    tick();
    bus.lsb_en = 1'b0;
    `CHK("ld4_done_pulse", bus.lsb_done, 1'b0)
    `CHK("ld4_no_reaccept", bus.dbg_state, IDLE)
    lsb_req(1'b0, 32'h200, 3'd1, 32'h0);
    tick();
    wait_done(1'b0, 10, e);
    bus.lsb_en = 1'b0;
    `CHK("ld1_done_edge", e, 2)
    `CHK("ld1_rdata", bus.lsb_rdata, 32'h0000_0011)
    tick();

    // 3. Halfword store
    exp_q.push_back({32'h0000_1000, 8'hEF});
    exp_q.push_back({32'h0000_1001, 8'hBE});
    lsb_req(1'b1, 32'h1000, 3'd2, 32'h0000_BEEF);
    tick();
    wait_done(1'b0, 10, e);
    bus.lsb_en = 1'b0;
    `CHK("st2_done_edge", e, 2)
    `CHK("st2_wr_low_at_done", bus.mem_wr, 1'b0)
    tick();
    tick();
    `CHK("st2_all_written", exp_q.size(), 0)

    // 4. Simultaneous requests: LSB first, one blocked edge, then the fill
    bus.if_pc = 32'h0000_2000;
    bus.if_en = 1'b1;
    lsb_req(1'b0, 32'h200, 3'd2, 32'h0);
    tick();
    `CHK("prio_lsb_addr", bus.mem_a, 32'h200)
    wait_done(1'b0, 10, e);
    bus.lsb_en = 1'b0;
    `CHK("prio_ld2_done_edge", e, 3)
    `CHK("prio_ld2_rdata", bus.lsb_rdata, 32'h0000_2211)
    tick();
    `CHK("prio_gap_addr", bus.mem_a, 32'h0)
    `CHK("prio_gap_lsb_done", bus.lsb_done, 1'b0)
    tick();
    `CHK("prio_fill_start", bus.mem_a, 32'h0000_2000)
    wait_done(1'b1, 80, e);
    bus.if_en = 1'b0;
    `CHK("prio_fill_done_edge", e, 65)
    `CHK("prio_fill_data_lo", bus.if_data[15:0], 16'h0100)
    `CHK("prio_fill_data_hi", bus.if_data[511:504], 8'h3F)
    tick();
    `CHK("prio_served_once", bus.dbg_state, IDLE)

    // 5a. Rollback aborts an LSB load
    lsb_req(1'b0, 32'h200, 3'd4, 32'h0);
    tick();
    tick();
    tick();
    bus.rollback = 1'b1;
    bus.lsb_en   = 1'b0;
    tick();
    bus.rollback = 1'b0;
    `CHK("rb_state", bus.dbg_state, IDLE)
    `CHK("rb_addr", bus.mem_a, 32'h0)
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.lsb_done !== 1'b0) bad++;
    end
    `CHK("rb_no_done", bad, 0)

    // 5a'. Rollback in the same IDLE edge blocks acceptance
    lsb_req(1'b0, 32'h200, 3'd4, 32'h0);
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    `CHK("rb_block_state", bus.dbg_state, IDLE)
    tick();
    `CHK("rb_retry_addr", bus.mem_a, 32'h200)
    wait_done(1'b0, 10, e);
    bus.lsb_en = 1'b0;
    `CHK("rb_retry_done_edge", e, 5)
    `CHK("rb_retry_rdata", bus.lsb_rdata, 32'h4433_2211)
    tick();

    // 5b. Rollback during a line fill is ignored
    bus.if_pc = 32'h0000_1040;
    bus.if_en = 1'b1;
    tick();
    repeat (9) tick();
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    `CHK("rb_fill_state", bus.dbg_state, READ)
    wait_done(1'b1, 80, e);
    bus.if_en = 1'b0;
    `CHK("rb_fill_done_edge", e, 65 - 10)
    `CHK("rb_fill_data", bus.if_data[31:0], 32'h4342_4140)
    tick();

    // 6. IO-region store stalls while the UART buffer is full
    exp_q.push_back({32'h0003_0000, 8'h5A});
    bus.io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h0003_0000, 3'd1, 32'h0000_005A);
    tick();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0) bad++;
      if (k < 4) tick();
    end
    `CHK("io_stall", bad, 0)
    bus.io_buffer_full = 1'b0;
    #1;
    `CHK("io_resume_wr", bus.mem_wr, 1'b1)
    `CHK("io_resume_addr", bus.mem_a, 32'h0003_0000)
    wait_done(1'b0, 5, e);
    bus.lsb_en = 1'b0;
    `CHK("io_done_edge", e, 1)
    tick();
    `CHK("io_all_written", exp_q.size(), 0)

    // 7. rdy low freezes acceptance; async reset mid-fill
    bus.rdy   = 1'b0;
    bus.if_pc = 32'h0000_1040;
    bus.if_en = 1'b1;
    repeat (3) tick();
    `CHK("rdy_freeze_state", bus.dbg_state, IDLE)
    `CHK("rdy_freeze_addr", bus.mem_a, 32'h0)
    bus.rdy = 1'b1;
    tick();
    `CHK("rdy_resume_addr", bus.mem_a, 32'h0000_1040)
    repeat (20) tick();
    `CHK("mid_fill_state", bus.dbg_state, READ)
    #2;
    rst = 1'b1;
    #1;
    `CHK("arst_state", bus.dbg_state, IDLE)
    `CHK("arst_mem_a", bus.mem_a, 32'h0)
    `CHK("arst_mem_wr", bus.mem_wr, 1'b0)
    `CHK("arst_if_done", bus.if_done, 1'b0)
    `CHK("arst_lsb_rdata", bus.lsb_rdata, 32'h0)
    `CHK("arst_if_data_lo", bus.if_data[63:0], 64'h0)
    `CHK("arst_if_data_hi", bus.if_data[511:448], 64'h0)
    bus.if_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory controller between the core and the byte-serial main RAM; it is the responder for the IFetch I-cache line-fill request and for LSB load/store requests. It serialises each request into byte accesses, reassembles read data, and returns a one-cycle done pulse. There is a single FSM with fixed LSB-over-IFetch priority.

Parameters:
LINE_BYTES, 64, bytes per I-cache line fill (ICACHE_LINE_WID = 8*LINE_BYTES bits)
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rdy  in  1  chip ready; when low, all state and outputs freeze
rollback  in  1  ROB mispredict flush
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  RAM write enable (1 = write)
io_buffer_full  in  1  UART buffer full; stalls IO-region stores
if_en  in  1  IFetch line request, held high until if_done is seen
if_pc  in  32  line base address (bits [5:0] masked to 0 internally)
if_done  out  1  one-cycle pulse: line valid
if_data  out  512  line data; byte k at bits [8k+7:8k]
lsb_en  in  1  LSB request, held until lsb_done
lsb_wr  in  1  1 = store, 0 = load
lsb_addr  in  32  byte address
lsb_len  in  3  bytes to transfer: 1, 2 or 4
lsb_wdata  in  32  store data, little-endian
lsb_done  out  1  one-cycle pulse: access complete
lsb_rdata  out  32  load data, zero-extended (LSB performs sign extension)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset, the state is IDLE and mem_a, mem_dout, mem_wr, if_done, lsb_done, lsb_rdata and cnt are all 0. if_data is cleared to 0.
- States:
  - IDLE: accept a request only when if_done=0 and lsb_done=0. This guard stops a held en from being re-accepted in the cycle the requester sees done.
  - Priority: lsb_en wins over if_en. A load goes to READ, a store goes to WRITE, an if_en goes to READ with N=LINE_BYTES.
- Read timing (RAM has registered output):
  - The request is accepted at edge A.
  - mem_a = base+k during the cycle after edge A+k, for k = 0..N-1.
  - Byte k is captured from mem_din at edge A+k+2.
  - The done pulse is set at edge A+N+1 and lasts exactly one cycle; the FSM returns to IDLE on that same edge.
  - Resulting latency: line fill is done 65 edges after acceptance; a 4-byte load at A+5.
- Write timing:
  - During the cycle after edge A+k, mem_wr=1, mem_a=base+k and mem_dout=lsb_wdata[8k+7:8k].
  - lsb_done is set at edge A+N, with mem_wr=0 from that edge.
- IO stall: for a store with addr[17:16]==IO_ADDR_HI, no byte is issued while io_buffer_full=1. mem_wr is held 0 and cnt does not advance; the store resumes the cycle after io_buffer_full falls.
- Rollback:
  - During a READ that serves the LSB, the FSM aborts to IDLE at that edge. No lsb_done is produced and mem_a goes to 0.
  - If rollback and lsb_en occur at the same IDLE edge, the request is not accepted.
  - WRITE (committed stores) is never aborted.
  - An IFetch line fill is never aborted, because IFetch keeps waiting for if_done after a rollback; the line completes normally.
- Outside transfers: mem_wr=0 and mem_a=0 whenever the FSM is not issuing.
- lsb_rdata: upper bytes beyond lsb_len are 0. lsb_rdata and if_data hold their values until the next completion.
- rdy=0: no register updates, outputs held.
- Address arithmetic: 32-bit with wrap-around. cnt is 7 bits.

Decomposition:
- def.v: ADDR_WID, ICACHE_LINE_WID, LINE_BYTES and the state encodings IDLE/READ/WRITE. Requester-select values SEL_IF/SEL_LSB also go there.
- No sub-module; one FSM plus a byte counter. Shifting byte capture into if_data/lsb_rdata lives inline.

Test Plan:
1. Line fill: RAM byte[i]=i[7:0], if_en=1, if_pc=0x1047 -> mem_a 0x1040..0x107F; if_done pulses once at A+65; if_data[31:0]=0x43424140, if_data[511:504]=0x7F.
2. Word load: RAM 0x200..0x203 = 11 22 33 44, lsb_len=4 -> lsb_rdata=0x44332211, lsb_done at A+5; lsb_len=1 gives 0x00000011 at A+2.
3. Halfword store: addr 0x1000, wdata 0x0000BEEF, len 2 -> mem_wr high 2 cycles, (0x1000,EF),(0x1001,BE), lsb_done at A+2, no third write.
4. Simultaneous if_en and lsb_en -> LSB served first. After lsb_done, one idle cycle, then the line fill starts; no request is served twice.
5. Rollback at A+3 of a 4-byte load -> no lsb_done, IDLE, mem_a=0. Rollback mid line fill -> fill continues; if_done still at A+65.
6. Store 1 byte to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0, then one write; asserting rst mid-line-fill zeroes all outputs immediately, without waiting for a clock edge.
